// File: rtl/alu_op_driver_if.sv
// ============================================================================
//  alu_op_driver_if : request / ALU / response bundle for alu_op_driver
//  Revision 1.0
// ============================================================================
`default_nettype none

interface alu_op_driver_if #(
    parameter int CNT_W = 16
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [3:0]       req_ctrl_i;
    logic [31:0]      req_a_i;
    logic [31:0]      req_b_i;
    logic [4:0]       req_shamt_i;
    logic [31:0]      alu_src1_o;
    logic [31:0]      alu_src2_o;
    logic [3:0]       alu_ctrl_o;
    logic [4:0]       alu_shamt_o;
    logic [31:0]      alu_result_i;
    logic             alu_zero_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_result_o;
    logic             rsp_zero_o;
    logic             rsp_taken_o;
    logic             rsp_illegal_o;
    logic             rsp_err_o;
    logic [CNT_W-1:0] op_cnt_o;

    // Driver side
    modport slave (
        input  req_valid_i, req_ctrl_i, req_a_i, req_b_i, req_shamt_i,
        input  alu_result_i, alu_zero_i, rsp_ready_i,
        output req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o,
        output rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_taken_o,
        output rsp_illegal_o, rsp_err_o, op_cnt_o
    );

    // Requester + ALU side
    modport master (
        output req_valid_i, req_ctrl_i, req_a_i, req_b_i, req_shamt_i,
        output alu_result_i, alu_zero_i, rsp_ready_i,
        input  req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o, alu_shamt_o,
        input  rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_taken_o,
        input  rsp_illegal_o, rsp_err_o, op_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/alu_op_driver.sv
// ============================================================================
//  alu_op_driver : registered request/response initiator for the MIPS ALU.
//  Optional reference-model check enabled by ALU_DRV_CHECK_EN.
//  Revision 1.0
// ============================================================================
`default_nettype none

module alu_op_driver #(
    parameter int CNT_W = 16
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    alu_op_driver_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SLT  = 4'b0111;
    localparam logic [3:0] c_OP_SRAV = 4'b1111;
    localparam logic [3:0] c_OP_SRA  = 4'b1110;
    localparam logic [3:0] c_OP_LUI  = 4'b1011;
    localparam logic [3:0] c_OP_BEQ  = 4'b0011;
    localparam logic [3:0] c_OP_BNE  = 4'b1001;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_req_ready;
    logic             w_rsp_valid;
    logic             w_req_legal;
    logic             w_accept;
    logic             w_rsp_done;

    logic [31:0]      r_src1;
    logic [31:0]      r_src2;
    logic [3:0]       r_ctrl;
    logic [4:0]       r_shamt;
    logic [31:0]      r_result;
    logic             r_zero;
    logic             r_taken;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_req_legal = 1'b0;
        case (bus.req_ctrl_i)
            c_OP_AND, c_OP_OR, c_OP_ADD, c_OP_SUB, c_OP_SLT,
            c_OP_SRAV, c_OP_SRA, c_OP_LUI, c_OP_BEQ, c_OP_BNE: w_req_legal = 1'b1;
            default:                                           w_req_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (bus.req_valid_i) w_state_nxt = w_req_legal ? c_ST_EXEC : c_ST_RESP;
            c_ST_EXEC: w_state_nxt = c_ST_RESP;
            c_ST_RESP: if (bus.rsp_ready_i) w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            c_ST_IDLE: w_req_ready = 1'b1;
            c_ST_RESP: w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept   = w_req_ready & bus.req_valid_i;
    assign w_rsp_done = w_rsp_valid & bus.rsp_ready_i;

    // Illegal requests leave the ALU drive registers untouched
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_src1    <= '0;
            r_src2    <= '0;
            r_ctrl    <= '0;
            r_shamt   <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept && w_req_legal) begin
                r_src1  <= bus.req_a_i;
                r_src2  <= bus.req_b_i;
                r_ctrl  <= bus.req_ctrl_i;
                r_shamt <= bus.req_shamt_i;
            end
            if (w_accept && !w_req_legal) begin
                r_result  <= '0;
                r_zero    <= 1'b0;
                r_taken   <= 1'b0;
                r_illegal <= 1'b1;
            end else if (r_state == c_ST_EXEC) begin
                r_result  <= bus.alu_result_i;
                r_zero    <= bus.alu_zero_i;
                r_taken   <= bus.alu_zero_i & ((r_ctrl == c_OP_BEQ) | (r_ctrl == c_OP_BNE));
                r_illegal <= 1'b0;
            end
            if (w_rsp_done) r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef ALU_DRV_CHECK_EN
    logic [31:0] w_exp_result;
    logic        w_exp_zero;
    logic        r_err;

    // BNE zero is inverted by the ALU, so the model inverts too
    always_comb begin
        w_exp_result = '0;
        case (r_ctrl)
            c_OP_AND:  w_exp_result = r_src1 & r_src2;
            c_OP_OR:   w_exp_result = r_src1 | r_src2;
            c_OP_ADD:  w_exp_result = r_src1 + r_src2;
            c_OP_SUB, c_OP_BEQ, c_OP_BNE: w_exp_result = r_src1 - r_src2;
            c_OP_SLT:  w_exp_result = {31'd0, (r_src1 < r_src2)};
            c_OP_SRAV: w_exp_result = (|r_src1[31:5]) ? {32{r_src2[31]}}
                                                      : $unsigned($signed(r_src2) >>> r_src1[4:0]);
            c_OP_SRA:  w_exp_result = $unsigned($signed(r_src2) >>> r_shamt);
            c_OP_LUI:  w_exp_result = {r_src2[15:0], 16'h0000};
            default:   w_exp_result = '0;
        endcase
        w_exp_zero = (w_exp_result == 32'd0) ^ (r_ctrl == c_OP_BNE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (r_state == c_ST_EXEC) begin
            r_err <= (w_exp_result != bus.alu_result_i) | (w_exp_zero != bus.alu_zero_i);
        end
    end

    assign bus.rsp_err_o = r_err;
`else
    assign bus.rsp_err_o = 1'b0;
`endif

    assign bus.req_ready_o   = w_req_ready;
    assign bus.rsp_valid_o   = w_rsp_valid;
    assign bus.alu_src1_o    = r_src1;
    assign bus.alu_src2_o    = r_src2;
    assign bus.alu_ctrl_o    = r_ctrl;
    assign bus.alu_shamt_o   = r_shamt;
    assign bus.rsp_result_o  = r_result;
    assign bus.rsp_zero_o    = r_zero;
    assign bus.rsp_taken_o   = r_taken;
    assign bus.rsp_illegal_o = r_illegal;
    assign bus.op_cnt_o      = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_driver.sv
// ============================================================================
//  tb_alu_op_driver : directed self-checking bench with a behavioural ALU stub.
//  Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_op_driver;

    // Narrow counter keeps the wrap scenario short
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    logic corrupt;
    int   n_chk;
    int   n_pass;
    logic [CNT_W-1:0] exp_cnt;

    alu_op_driver_if #(.CNT_W(CNT_W)) bus ();

    alu_op_driver #(.CNT_W(CNT_W)) u_dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stub in front of the driver
    logic [31:0] alu_r;
    always_comb begin
        alu_r = 32'd0;
        case (bus.alu_ctrl_o)
            4'b0000: alu_r = bus.alu_src1_o & bus.alu_src2_o;
            4'b0001: alu_r = bus.alu_src1_o | bus.alu_src2_o;
            4'b0010: alu_r = bus.alu_src1_o + bus.alu_src2_o;
            4'b0110, 4'b0011, 4'b1001: alu_r = bus.alu_src1_o - bus.alu_src2_o;
            4'b0111: alu_r = {31'd0, bus.alu_src1_o < bus.alu_src2_o};
            4'b1111: alu_r = (bus.alu_src1_o >= 32'd32) ? {32{bus.alu_src2_o[31]}}
                                                        : $unsigned($signed(bus.alu_src2_o) >>> bus.alu_src1_o[4:0]);
            4'b1110: alu_r = $unsigned($signed(bus.alu_src2_o) >>> bus.alu_shamt_o);
            4'b1011: alu_r = {bus.alu_src2_o[15:0], 16'h0000};
            default: alu_r = 32'd0;
        endcase
        bus.alu_result_i = alu_r ^ {31'd0, corrupt};
        bus.alu_zero_i   = ((alu_r ^ {31'd0, corrupt}) == 32'd0) ^ (bus.alu_ctrl_o == 4'b1001);
    end

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
        bus.req_ctrl_i  = c;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        bus.req_shamt_i = sh;
        bus.req_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready_i = 1'b0;
        exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_chk++; if (bus.req_ready_o !== 1'b1) $display("FAIL rst_ready got %b exp 1", bus.req_ready_o); else n_pass++;
        n_chk++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL rst_valid got %b exp 0", bus.rsp_valid_o); else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(4'b0010, 32'd5, 32'd7, 5'd0);
        n_chk++; if (bus.alu_src2_o !== 32'd7) $display("FAIL exec_src2 got %h exp 7", bus.alu_src2_o); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.alu_src1_o, bus.alu_src2_o, bus.alu_ctrl_o, bus.rsp_result_o} !== 100'd0)
            $display("FAIL midexec_rst_outs got %h/%h/%h/%h exp 0", bus.alu_src1_o, bus.alu_src2_o, bus.alu_ctrl_o, bus.rsp_result_o); else n_pass++;
        n_chk++; if (bus.req_ready_o !== 1'b1) $display("FAIL midexec_rst_ready got %b exp 1", bus.req_ready_o); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL midexec_no_rsp got %b exp 0", bus.rsp_valid_o); else n_pass++;
        n_chk++; if (bus.op_cnt_o !== 8'd0) $display("FAIL rst_cnt got %0d exp 0", bus.op_cnt_o); else n_pass++;
        n_chk++; if (bus.req_ready_o !== 1'b1) $display("FAIL post_rst_ready got %b exp 1", bus.req_ready_o); else n_pass++;
    endtask

    task automatic test_add();
        send(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
        n_chk++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL add_early_valid got %b exp 0", bus.rsp_valid_o); else n_pass++;
        n_chk++; if (bus.alu_src1_o !== 32'h7FFFFFFF) $display("FAIL add_src1 got %h exp 7fffffff", bus.alu_src1_o); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (bus.rsp_valid_o !== 1'b1) $display("FAIL add_valid got %b exp 1", bus.rsp_valid_o); else n_pass++;
        n_chk++; if (bus.rsp_result_o !== 32'h80000000) $display("FAIL add_result got %h exp 80000000", bus.rsp_result_o); else n_pass++;
        n_chk++; if ({bus.rsp_zero_o, bus.rsp_taken_o, bus.rsp_illegal_o, bus.rsp_err_o} !== 4'b0000)
            $display("FAIL add_flags got %b exp 0000", {bus.rsp_zero_o, bus.rsp_taken_o, bus.rsp_illegal_o, bus.rsp_err_o}); else n_pass++;
        finish_rsp();
        n_chk++; if (bus.op_cnt_o !== 8'd1) $display("FAIL add_cnt got %0d exp 1", bus.op_cnt_o); else n_pass++;
        n_chk++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL add_valid_drop got %b exp 0", bus.rsp_valid_o); else n_pass++;
    endtask

    task automatic test_branch();
        send(4'b0011, 32'h1234, 32'h1234, 5'd0);
        @(posedge clk); #1;
        n_chk++; if ({bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_taken_o} !== {32'd0, 2'b11})
            $display("FAIL beq_eq got %h z%b t%b exp 0 z1 t1", bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_taken_o); else n_pass++;
        finish_rsp();
        send(4'b1001, 32'd3, 32'd3, 5'd0);
        @(posedge clk); #1;
        n_chk++; if ({bus.rsp_zero_o, bus.rsp_taken_o} !== 2'b00)
            $display("FAIL bne_eq got z%b t%b exp z0 t0", bus.rsp_zero_o, bus.rsp_taken_o); else n_pass++;
        finish_rsp();
        send(4'b1001, 32'd3, 32'd4, 5'd0);
        @(posedge clk); #1;
        n_chk++; if ({bus.rsp_zero_o, bus.rsp_taken_o} !== 2'b11)
            $display("FAIL bne_ne got z%b t%b exp z1 t1", bus.rsp_zero_o, bus.rsp_taken_o); else n_pass++;
        finish_rsp();
        send(4'b0110, 32'd9, 32'd4, 5'd0);
        @(posedge clk); #1;
        n_chk++; if ({bus.rsp_result_o, bus.rsp_taken_o} !== {32'd5, 1'b0})
            $display("FAIL sub_notbranch got %h t%b exp 5 t0", bus.rsp_result_o, bus.rsp_taken_o); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_shift();
        send(4'b1110, 32'd0, 32'h80000000, 5'd4);
        @(posedge clk); #1;
        n_chk++; if (bus.rsp_result_o !== 32'hF8000000) $display("FAIL sra got %h exp f8000000", bus.rsp_result_o); else n_pass++;
        finish_rsp();
        send(4'b1111, 32'd40, 32'h80000000, 5'd0);
        @(posedge clk); #1;
        n_chk++; if (bus.rsp_result_o !== 32'hFFFFFFFF) $display("FAIL srav got %h exp ffffffff", bus.rsp_result_o); else n_pass++;
        finish_rsp();
        send(4'b1011, 32'd0, 32'h0000ABCD, 5'd0);
        @(posedge clk); #1;
        n_chk++; if (bus.rsp_result_o !== 32'hABCD0000) $display("FAIL lui got %h exp abcd0000", bus.rsp_result_o); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_illegal();
        send(4'b0101, 32'hDEAD, 32'hBEEF, 5'd7);
        n_chk++; if (bus.rsp_valid_o !== 1'b1) $display("FAIL ill_valid got %b exp 1", bus.rsp_valid_o); else n_pass++;
        n_chk++; if ({bus.rsp_illegal_o, bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_taken_o} !== {1'b1, 34'd0})
            $display("FAIL ill_rsp got i%b %h z%b t%b exp i1 0 z0 t0", bus.rsp_illegal_o, bus.rsp_result_o, bus.rsp_zero_o, bus.rsp_taken_o); else n_pass++;
        n_chk++; if ({bus.alu_src1_o, bus.alu_src2_o, bus.alu_ctrl_o, bus.alu_shamt_o} !== {32'd0, 32'h0000ABCD, 4'b1011, 5'd0})
            $display("FAIL ill_alu_hold got %h %h %h %h exp 0 abcd b 0", bus.alu_src1_o, bus.alu_src2_o, bus.alu_ctrl_o, bus.alu_shamt_o); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_backpressure();
        send(4'b0001, 32'hF0, 32'h0F, 5'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            n_chk++; if ({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_result_o, bus.rsp_illegal_o} !== {2'b10, 32'hFF, 1'b0})
                $display("FAIL bp_hold cyc%0d got v%b r%b %h exp v1 r0 ff", i, bus.rsp_valid_o, bus.req_ready_o, bus.rsp_result_o); else n_pass++;
            @(posedge clk); #1;
        end
        finish_rsp();
        n_chk++; if (bus.op_cnt_o !== exp_cnt) $display("FAIL bp_cnt got %0d exp %0d", bus.op_cnt_o, exp_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        send(4'b0000, 32'hFF00FF00, 32'h0FF00FF0, 5'd0);
        @(posedge clk); #1;
        finish_rsp();
        n_chk++; if (bus.req_ready_o !== 1'b1) $display("FAIL b2b_ready got %b exp 1", bus.req_ready_o); else n_pass++;
        send(4'b0111, 32'd1, 32'hFFFFFFFF, 5'd0);
        @(posedge clk); #1;
        n_chk++; if ({bus.rsp_valid_o, bus.rsp_result_o} !== {1'b1, 32'd1})
            $display("FAIL b2b_slt got v%b %h exp v1 1", bus.rsp_valid_o, bus.rsp_result_o); else n_pass++;
        finish_rsp();
    endtask

    task automatic test_wrap();
        while (exp_cnt != 8'hFF) begin
            send(4'b1100, 32'd0, 32'd0, 5'd0);
            finish_rsp();
        end
        n_chk++; if (bus.op_cnt_o !== 8'hFF) $display("FAIL wrap_full got %h exp ff", bus.op_cnt_o); else n_pass++;
        send(4'b1100, 32'd0, 32'd0, 5'd0);
        finish_rsp();
        n_chk++; if (bus.op_cnt_o !== 8'h00) $display("FAIL wrap_zero got %h exp 00", bus.op_cnt_o); else n_pass++;
    endtask

    task automatic test_check();
        corrupt = 1'b1;
        send(4'b0010, 32'd1, 32'd2, 5'd0);
        @(posedge clk); #1;
        n_chk++; if (bus.rsp_result_o !== 32'd2) $display("FAIL chk_corrupt_result got %h exp 2", bus.rsp_result_o); else n_pass++;
`ifdef ALU_DRV_CHECK_EN
        n_chk++; if (bus.rsp_err_o !== 1'b1) $display("FAIL chk_err got %b exp 1", bus.rsp_err_o); else n_pass++;
`else
        n_chk++; if (bus.rsp_err_o !== 1'b0) $display("FAIL chk_err_tied got %b exp 0", bus.rsp_err_o); else n_pass++;
`endif
        finish_rsp();
        corrupt = 1'b0;
        send(4'b1110, 32'd0, 32'h40000000, 5'd30);
        @(posedge clk); #1;
        n_chk++; if ({bus.rsp_result_o, bus.rsp_err_o} !== {32'd1, 1'b0})
            $display("FAIL chk_clean got %h e%b exp 1 e0", bus.rsp_result_o, bus.rsp_err_o); else n_pass++;
        finish_rsp();
    endtask

    initial begin
        n_chk           = 0;
        n_pass          = 0;
        exp_cnt         = '0;
        corrupt         = 1'b0;
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_ctrl_i  = 4'd0;
        bus.req_a_i     = 32'd0;
        bus.req_b_i     = 32'd0;
        bus.req_shamt_i = 5'd0;
        bus.rsp_ready_i = 1'b0;

        test_reset();
        test_add();
        test_branch();
        test_shift();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_check();
        test_wrap();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_op_driver.md
# alu_op_driver

Sequential initiator for the combinational 32-bit ALU of the single-cycle MIPS datapath. It accepts operation requests over a valid/ready handshake, drives the ALU operand/control/shamt inputs from registers, and captures the ALU result and zero flag one cycle later. It returns them, with a branch-taken decision, over a valid/ready response channel. It serves as the bridge for multi-cycle datapath work and for in-system ALU self-checking.

## Interface
Parameters:
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_ctrl_i  in  4  ALU control code.
- req_a_i  in  32  operand 1.
- req_b_i  in  32  operand 2.
- req_shamt_i  in  5  shift amount.
- alu_src1_o  out  32  to ALU src1_i.
- alu_src2_o  out  32  to ALU src2_i.
- alu_ctrl_o  out  4  to ALU ctrl_i.
- alu_shamt_o  out  5  to ALU shamt_i.
- alu_result_i  in  32  from ALU result_o.
- alu_zero_i  in  1  from ALU zero_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
- rsp_result_o  out  32  captured result.
- rsp_zero_o  out  1  captured zero flag.
- rsp_taken_o  out  1  branch taken (beq/bne only).
- rsp_illegal_o  out  1  request carried an unsupported ctrl code.
- rsp_err_o  out  1  result mismatch against the internal model (check build only).
- op_cnt_o  out  CNT_W  completed responses, wraps.

## Operation
- Legal codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1111 SRAV, 1110 SRA, 1011 LUI, 0011 BEQ, 1001 BNE. All other codes are illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready_o=1.
  - Legal request handshake: latch a/b/ctrl/shamt into alu_* registers, then go to EXEC.
  - Illegal request handshake: alu_* registers are not modified. Load rsp_result_o=0, rsp_zero_o=0, rsp_taken_o=0, rsp_illegal_o=1, then go to RESP.
- EXEC: req_ready_o=0. At the edge, capture alu_result_i into rsp_result_o and alu_zero_i into rsp_zero_o. Set rsp_taken_o=alu_zero_i for ctrl 0011 or 1001, otherwise 0. Set rsp_illegal_o=0. Go to RESP.
- RESP: rsp_valid_o=1 and all rsp_* held stable. On rsp_ready_i: increment op_cnt_o (all-ones wraps to 0) and go to IDLE.
  - No request is accepted in RESP. A back-to-back request is accepted in the IDLE cycle after the response handshake.
- alu_* outputs hold their last issued values outside EXEC.
- ALU zero convention: for BNE, alu_zero_i is already inverted (1 means not equal), so BNE is taken when alu_zero_i=1.
- Reset (async, any state, including mid-EXEC/RESP):
  - FSM goes to IDLE.
  - All outputs go to 0, except req_ready_o, which is 1 once in IDLE.
  - An in-flight operation is discarded with no response.

## Timing
- Accept edge N → ALU inputs valid after edge N → capture at edge N+1 → rsp_valid_o high from N+1.
- Latency: 1 cycle from accept to response for legal codes; illegal codes respond from edge N.
- Throughput: at most one operation per 3 cycles with rsp_ready_i held high.
- The ALU combinational path (including zero derived from result) has one full cycle to settle.

## Configuration
- ALU_DRV_CHECK_EN defined: an internal reference model computes the expected result and zero in EXEC:
  - SLT: unsigned compare.
  - SRAV: arithmetic shift of b by the unsigned value of a; a ≥ 32 gives full sign fill.
  - SRA: b >>> shamt.
  - LUI: b<<16.
  - BEQ/BNE: a−b.
  - Zero = (result==0), inverted for BNE.
  - rsp_err_o=1 in RESP if result or zero differs from alu_*_i.
- ALU_DRV_CHECK_EN undefined: no model logic; rsp_err_o is tied to 0.

## Test plan
- Reset asserted mid-EXEC (ADD, a=5, b=7) → no response; all outputs 0; req_ready_o=1 after release; op_cnt_o=0.
- ADD a=0x7FFFFFFF, b=1 → rsp_result_o=0x80000000, rsp_zero_o=0, rsp_valid_o exactly one cycle after accept; op_cnt_o=1 after handshake.
- BEQ a=b=0x1234 → result 0, zero=1, taken=1. BNE a=3, b=3 → zero=0, taken=0. BNE a=3, b=4 → taken=1.
- SRA b=0x80000000, shamt=4 → 0xF8000000. SRAV a=40, b=0x80000000 → 0xFFFFFFFF. LUI b=0xABCD → 0xABCD0000.
- Illegal ctrl 0101 → rsp_illegal_o=1, result 0, alu_* outputs unchanged, response from the cycle after accept.
- rsp_ready_i held low 5 cycles → rsp_* stable and req_ready_o=0. Preload op_cnt_o to all-ones via 65535 ops → next handshake wraps to 0. Check build: ALU stub returning a corrupted result → rsp_err_o=1.
